pool_fmap_buffer: RTL and testbench



---
 rtl/pool_fmap_buffer.sv | 183 ++++++++++++++++++
 tb/tb_pool_fmap_buffer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pool_fmap_buffer.sv
// Pooled feature-map frame buffer: captures a raster frame from the pool stage and replays it over valid/ready.
// Optional two-bank ping-pong operation when POOL_BUF_PINGPONG_EN is defined.
module pool_fmap_ram #(
  parameter int DW = 12,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  // rdata holds when re=0; the read pipeline relies on that during stalls
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

module pool_fmap_buffer #(
  parameter int DATA_BIT    = 12,
  parameter int HALF_WIDTH  = 12,
  parameter int HALF_HEIGHT = 12,
  parameter int ADDR_BIT    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_in,
  input  logic [DATA_BIT-1:0] data_in_1,
  input  logic [DATA_BIT-1:0] data_in_2,
  input  logic [DATA_BIT-1:0] data_in_3,
  input  logic                ready_out,
  output logic                valid_out,
  output logic [DATA_BIT-1:0] data_out_1,
  output logic [DATA_BIT-1:0] data_out_2,
  output logic [DATA_BIT-1:0] data_out_3,
  output logic                out_last,
  output logic                frame_done,
  output logic                overflow
);
  localparam int DEPTH     = HALF_WIDTH * HALF_HEIGHT;
  localparam int NUM_LANES = 3;
  localparam int STAGES    = 2;
`ifdef POOL_BUF_PINGPONG_EN
  localparam int BANKS = 2;
`else
  localparam int BANKS = 1;
`endif
  localparam int MEM_AW = ADDR_BIT + $clog2(BANKS);
  localparam logic [ADDR_BIT-1:0] LAST_ADDR = ADDR_BIT'(DEPTH - 1);

  logic [NUM_LANES-1:0][DATA_BIT-1:0] din, rdata, dout_q;
  logic                wr_en, rd_en, advance, hs, s1_last;
  logic [MEM_AW-1:0]   wr_addr, rd_addr;
  logic [ADDR_BIT-1:0] wr_ptr, rd_ptr;
  logic [STAGES:1]     vld_pipe;

  assign din        = {data_in_3, data_in_2, data_in_1};
  assign data_out_1 = dout_q[0];
  assign data_out_2 = dout_q[1];
  assign data_out_3 = dout_q[2];
  assign valid_out  = vld_pipe[STAGES];
  assign advance    = !vld_pipe[STAGES] || ready_out;
  assign hs         = vld_pipe[STAGES] && ready_out;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    pool_fmap_ram #(.DW(DATA_BIT), .AW(MEM_AW)) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (din[l]),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (rdata[l])
    );
  end

  // Stall-as-a-whole read pipeline: RAM read stage then output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      s1_last    <= 1'b0;
      out_last   <= 1'b0;
      dout_q     <= '0;
      frame_done <= 1'b0;
      rd_ptr     <= '0;
    end else begin
      frame_done <= hs && out_last;
      if (rd_en) rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
      if (advance) begin
        vld_pipe[1]      <= rd_en;
        s1_last          <= rd_en && (rd_ptr == LAST_ADDR);
        vld_pipe[STAGES] <= vld_pipe[1];
        out_last         <= vld_pipe[1] && s1_last;
        if (vld_pipe[1]) dout_q <= rdata;
      end
    end
  end

`ifdef POOL_BUF_PINGPONG_EN
  logic [1:0] full;
  logic       wb, ib, s1_bank, out_bank;

  assign wr_en   = valid_in && !full[wb];
  assign rd_en   = advance && full[ib];
  assign wr_addr = {wb, wr_ptr};
  assign rd_addr = {ib, rd_ptr};

  // Set and clear never hit the same bank: wb is never a full bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= '0;
      wb       <= 1'b0;
      ib       <= 1'b0;
      s1_bank  <= 1'b0;
      out_bank <= 1'b0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (valid_in && full[wb]) overflow <= 1'b1;
      if (wr_en) begin
        if (wr_ptr == LAST_ADDR) begin
          wr_ptr   <= '0;
          full[wb] <= 1'b1;
          wb       <= ~wb;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      if (rd_en && rd_ptr == LAST_ADDR) ib <= ~ib;
      if (advance) begin
        s1_bank  <= ib;
        out_bank <= s1_bank;
      end
      if (hs && out_last) full[out_bank] <= 1'b0;
    end
  end
`else
  typedef enum logic {FILL, DRAIN} state_t;
  state_t state, state_nxt;
  logic   issued;

  assign wr_addr = wr_ptr;
  assign rd_addr = rd_ptr;

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    case (state)
      FILL: begin
        wr_en = valid_in;
        if (valid_in && wr_ptr == LAST_ADDR) state_nxt = DRAIN;
      end
      DRAIN: begin
        rd_en = advance && !issued;
        if (hs && out_last) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      wr_ptr   <= '0;
      issued   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_en) wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
      if (valid_in && state == DRAIN) overflow <= 1'b1;
      // issued stops new reads once the whole frame is in flight
      if (rd_en && rd_ptr == LAST_ADDR) issued <= 1'b1;
      else if (hs && out_last)          issued <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_pool_fmap_buffer.sv
// Directed bench for pool_fmap_buffer: frame capture/replay, backpressure, gaps, overflow, reset, ping-pong.
module tb_pool_fmap_buffer;
  localparam int DW = 12;
  localparam int DEPTH = 144;

  logic clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0, ready_out = 1'b1;
  logic [DW-1:0] data_in_1 = '0, data_in_2 = '0, data_in_3 = '0;
  logic valid_out, out_last, frame_done, overflow;
  logic [DW-1:0] data_out_1, data_out_2, data_out_3;

  always #5 clk = ~clk;

  pool_fmap_buffer #(.DATA_BIT(DW), .HALF_WIDTH(12), .HALF_HEIGHT(12), .ADDR_BIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
    .ready_out(ready_out), .valid_out(valid_out),
    .data_out_1(data_out_1), .data_out_2(data_out_2), .data_out_3(data_out_3),
    .out_last(out_last), .frame_done(frame_done), .overflow(overflow)
  );

  int n_chk = 0, n_pass = 0;
  int idx = 0, fd_cnt = 0, n_px = DEPTH, rdy_mode = 0, pcnt = 0;
  logic fd_next = 1'b0;
  logic [35:0] exp_px [2*DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic mon_reset();
    idx = 0; fd_cnt = 0; fd_next = 1'b0;
  endtask

  task automatic fill_exp(input int kind);
    for (int i = 0; i < 2*DEPTH; i++)
      exp_px[i] = (kind == 0) ? {DW'(i), DW'(i + 256), DW'(4095 - i)} : {DW'(7), DW'(7), DW'(7)};
  endtask

  // One clock: check outputs at the falling edge, then drive ready just after the rising edge
  task automatic cyc();
    @(negedge clk);
    chk("frame_done", 64'(frame_done), 64'(fd_next));
    if (frame_done) fd_cnt++;
    fd_next = 1'b0;
    if (valid_out) begin
      if (idx >= n_px) chk("extra_xfer", 64'(idx), 64'(n_px - 1));
      else begin
        chk("data", 64'({data_out_1, data_out_2, data_out_3}), 64'(exp_px[idx]));
        chk("out_last", 64'(out_last), 64'((idx % DEPTH) == DEPTH - 1));
      end
      if (ready_out) begin
        fd_next = ((idx % DEPTH) == DEPTH - 1);
        idx++;
      end
    end
    @(posedge clk); #1;
    case (rdy_mode)
      1:       ready_out = (pcnt % 4 == 0) || (pcnt % 4 == 3);
      2:       ready_out = 1'b0;
      default: ready_out = 1'b1;
    endcase
    pcnt++;
  endtask

  task automatic wr_frame(input int n, input int gap, input int kind);
    for (int i = 0; i < n; i++) begin
      repeat (gap) cyc();
      valid_in  = 1'b1;
      data_in_1 = (kind == 0) ? DW'(i)        : DW'(7);
      data_in_2 = (kind == 0) ? DW'(i + 256)  : DW'(7);
      data_in_3 = (kind == 0) ? DW'(4095 - i) : DW'(7);
      cyc();
      valid_in = 1'b0;
    end
  endtask

  task automatic latency(input string tag);
    chk({tag, "_lat0"}, 64'(valid_out), 64'd0);
    cyc();
    chk({tag, "_lat1"}, 64'(valid_out), 64'd0);
    cyc();
    chk({tag, "_lat2"}, 64'(valid_out), 64'd1);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (idx < n_px && k < 3000) begin cyc(); k++; end
    chk({tag, "_in_time"}, 64'(k < 3000), 64'd1);
    cyc(); cyc();
    chk({tag, "_count"}, 64'(idx), 64'(n_px));
    chk({tag, "_fd_pulses"}, 64'(fd_cnt), 64'(n_px / DEPTH));
    chk({tag, "_valid_idle"}, 64'(valid_out), 64'd0);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    mon_reset();
  endtask

  initial begin
    fill_exp(0);
    #3;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_fd", 64'(frame_done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_data", 64'({data_out_1, data_out_2, data_out_3}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // basic frame
    mon_reset();
    wr_frame(DEPTH, 0, 0);
    latency("basic");
    drain("basic");
    chk("basic_ovf", 64'(overflow), 64'd0);

    // backpressure 1,0,0,1
    mon_reset(); rdy_mode = 1;
    wr_frame(DEPTH, 0, 0);
    drain("bp");
    rdy_mode = 0;

    // one write in three
    mon_reset();
    wr_frame(DEPTH, 2, 0);
    latency("gap");
    drain("gap");

`ifndef POOL_BUF_PINGPONG_EN
    // drops while stalled in drain
    begin
      int k = 0;
      mon_reset(); rdy_mode = 2;
      wr_frame(DEPTH, 0, 0);
      while (!valid_out && k < 20) begin cyc(); k++; end
      chk("ovf_valid_seen", 64'(valid_out), 64'd1);
      for (int i = 0; i < 5; i++) begin
        valid_in = 1'b1; data_in_1 = DW'(999); data_in_2 = DW'(999); data_in_3 = DW'(999);
        cyc();
      end
      valid_in = 1'b0;
      chk("ovf_set", 64'(overflow), 64'd1);
      rdy_mode = 0;
      drain("ovf");
      chk("ovf_hold", 64'(overflow), 64'd1);
      mon_reset();
      wr_frame(DEPTH, 0, 0);
      drain("ovf_next");
      chk("ovf_sticky", 64'(overflow), 64'd1);
      do_reset();
      chk("ovf_cleared", 64'(overflow), 64'd0);
    end
`endif

    // asynchronous reset in the middle of a drain
    begin
      int k = 0;
      mon_reset();
      wr_frame(DEPTH, 0, 0);
      while (idx < 50 && k < 400) begin cyc(); k++; end
      chk("mid_hs50", 64'(idx), 64'd50);
      #1 rst_n = 1'b0;
      #1 chk("mid_valid_low", 64'(valid_out), 64'd0);
      #1 rst_n = 1'b1;
      mon_reset(); fill_exp(1);
      wr_frame(DEPTH, 0, 1);
      latency("sevens");
      drain("sevens");
      fill_exp(0);
    end

`ifdef POOL_BUF_PINGPONG_EN
    do_reset();
    n_px = 2 * DEPTH;
    wr_frame(2 * DEPTH, 0, 0);
    drain("pp");
    chk("pp_ovf", 64'(overflow), 64'd0);
    n_px = DEPTH;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
